// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite plotter.
//   - state_t        : plotter FSM states
//   - SPR_PIX        : pixels per sprite (13 full bird, 10 when SPRITE_FLAP_EN
//                      is defined: 7 body pixels + 3 wing pixels)
//   - DX_W / DY_W    : signed width of shape offsets
//   - K_W            : width of the pixel counter
//   - BIRD_DX/BIRD_DY: full bird shape, pixel order k = 0..12
// Build option: SPRITE_FLAP_EN (see sprite_shape_rom / sprite_plotter).
package sprite_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEL,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam int DX_W = 4;
  localparam int DY_W = 4;
  localparam int K_W  = 4;

`ifdef SPRITE_FLAP_EN
  localparam int SPR_PIX = 10;
`else
  localparam int SPR_PIX = 13;
`endif

  // Body first (k 0..6), then wings in up/down pairs (k 7..12).
  localparam logic signed [DX_W-1:0] BIRD_DX [13] = '{
    4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5,
    -4'sd3, -4'sd3, -4'sd4, -4'sd4, -4'sd5, -4'sd5
  };
  localparam logic signed [DY_W-1:0] BIRD_DY [13] = '{
    4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0,
    4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3
  };

endpackage

// File: rtl/sprite_shape_rom.sv
// sprite_shape_rom: combinational shape table for the bird sprite.
// Ports:
//   k     in  K_W   pixel index within the shape
//   phase in  1     wing phase (0 = wings up, 1 = wings down); only
//                   meaningful when SPRITE_FLAP_EN is defined
//   dx    out DX_W  signed x offset from the anchor
//   dy    out DY_W  signed y offset from the anchor
// Indices past the end of the shape return (0,0).
module sprite_shape_rom
  import sprite_pkg::*;
(
  input  logic [K_W-1:0]         k,
  input  logic                   phase,
  output logic signed [DX_W-1:0] dx,
  output logic signed [DY_W-1:0] dy
);

  int idx;

`ifdef SPRITE_FLAP_EN
  int wing;

  always_comb begin
    dx   = '0;
    dy   = '0;
    idx  = int'(k);
    wing = 0;
    if (idx < 7) begin
      dx = BIRD_DX[idx];
      dy = BIRD_DY[idx];
    end else if (idx < 10) begin
      // Up wings sit at table entries 7, 9, 11; down wings mirror them in y.
      wing = 7 + 2 * (idx - 7);
      dx   = BIRD_DX[wing];
      dy   = phase ? -BIRD_DY[wing] : BIRD_DY[wing];
    end
  end
`else
  logic unused_phase;
  assign unused_phase = phase;

  always_comb begin
    dx  = '0;
    dy  = '0;
    idx = int'(k);
    if (idx < 13) begin
      dx = BIRD_DX[idx];
      dy = BIRD_DY[idx];
    end
  end
`endif

endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: multi-sprite erase/redraw engine feeding vga_adapter.
// On each frame_tick (when idle) it snapshots all slot inputs, then walks the
// slots in ascending order: erase the shape at last frame's position with
// bg_colour, then draw it at the new position with the slot colour. One
// pixel per clock; off-screen pixels still take their cycle but plot=0.
// Ports:
//   clock, resetn         clock, synchronous active-low reset
//   frame_tick            1-cycle pass request; dropped (overrun) when busy
//   active                per-slot enable
//   pos_x/pos_y           packed anchor coordinates, slot i at [i*W +: W]
//   spr_colour/bg_colour  draw colour per slot / erase colour
//   x, y, colour, plot    pixel write port
//   busy                  high from LOAD through DONE
//   done                  1-cycle pulse in DONE
//   overrun               1-cycle pulse after a tick arrived while busy
// Build option SPRITE_FLAP_EN: 10-pixel sprite whose wing phase toggles
// every pass; each slot remembers the phase it was drawn with for its erase.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 7,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COL_W       = 3,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         frame_tick,
  input  logic [NUM_SPRITES-1:0]       active,
  input  logic [NUM_SPRITES*X_W-1:0]   pos_x,
  input  logic [NUM_SPRITES*Y_W-1:0]   pos_y,
  input  logic [NUM_SPRITES*COL_W-1:0] spr_colour,
  input  logic [COL_W-1:0]             bg_colour,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COL_W-1:0]             colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(NUM_SPRITES - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(SPR_PIX - 1);
  localparam logic [X_W-1:0]   X_LIM     = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_LIM     = Y_W'(Y_MAX);

  state_t                 state;
  logic [IDX_W-1:0]       slot;
  logic [K_W-1:0]         k;
  logic [NUM_SPRITES-1:0] active_snap;
  logic [NUM_SPRITES-1:0] prev_drawn;
  logic                   overrun_q;

  logic [X_W-1:0]   new_x   [NUM_SPRITES];
  logic [Y_W-1:0]   new_y   [NUM_SPRITES];
  logic [COL_W-1:0] new_col [NUM_SPRITES];
  logic [X_W-1:0]   old_x   [NUM_SPRITES];
  logic [Y_W-1:0]   old_y   [NUM_SPRITES];

`ifdef SPRITE_FLAP_EN
  logic                   phase_q;
  logic [NUM_SPRITES-1:0] old_phase;
`endif

  logic last_slot;
  assign last_slot = (slot == SLOT_LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      slot        <= '0;
      k           <= '0;
      active_snap <= '0;
      prev_drawn  <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        new_x[i]   <= '0;
        new_y[i]   <= '0;
        new_col[i] <= '0;
        old_x[i]   <= '0;
        old_y[i]   <= '0;
      end
`ifdef SPRITE_FLAP_EN
      phase_q   <= 1'b0;
      old_phase <= '0;
`endif
    end else begin
      overrun_q <= frame_tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (frame_tick) state <= S_LOAD;
        end
        S_LOAD: begin
          active_snap <= active;
          for (int i = 0; i < NUM_SPRITES; i++) begin
            new_x[i]   <= pos_x[i*X_W +: X_W];
            new_y[i]   <= pos_y[i*Y_W +: Y_W];
            new_col[i] <= spr_colour[i*COL_W +: COL_W];
          end
          slot  <= '0;
          state <= S_SEL;
        end
        S_SEL: begin
          k <= '0;
          if (prev_drawn[slot]) begin
            state <= S_ERASE;
          end else if (active_snap[slot]) begin
            state <= S_DRAW;
          end else begin
            prev_drawn[slot] <= 1'b0;
            if (last_slot) state <= S_DONE;
            else begin
              slot  <= slot + 1'b1;
              state <= S_SEL;
            end
          end
        end
        S_ERASE: begin
          if (k == K_LAST) begin
            k <= '0;
            if (active_snap[slot]) begin
              state <= S_DRAW;
            end else begin
              prev_drawn[slot] <= 1'b0;
              if (last_slot) state <= S_DONE;
              else begin
                slot  <= slot + 1'b1;
                state <= S_SEL;
              end
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAW: begin
          if (k == K_LAST) begin
            k                <= '0;
            old_x[slot]      <= new_x[slot];
            old_y[slot]      <= new_y[slot];
            prev_drawn[slot] <= 1'b1;
`ifdef SPRITE_FLAP_EN
            old_phase[slot]  <= phase_q;
`endif
            if (last_slot) state <= S_DONE;
            else begin
              slot  <= slot + 1'b1;
              state <= S_SEL;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
`ifdef SPRITE_FLAP_EN
          phase_q <= ~phase_q;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel datapath: everything below decodes straight from the registered
  // state and counters, so a pixel appears in the same cycle as its state.
  logic                   rom_phase;
  logic signed [DX_W-1:0] dx;
  logic signed [DY_W-1:0] dy;
  logic [X_W-1:0]         anchor_x;
  logic [Y_W-1:0]         anchor_y;
  logic [COL_W-1:0]       pix_col;
  logic signed [X_W:0]    sum_x;
  logic signed [Y_W:0]    sum_y;
  logic                   pix_state;
  logic                   on_screen;

  sprite_shape_rom u_rom (
    .k     (k),
    .phase (rom_phase),
    .dx    (dx),
    .dy    (dy)
  );

  always_comb begin
    anchor_x  = new_x[slot];
    anchor_y  = new_y[slot];
    pix_col   = new_col[slot];
`ifdef SPRITE_FLAP_EN
    rom_phase = phase_q;
`else
    rom_phase = 1'b0;
`endif
    if (state == S_ERASE) begin
      anchor_x = old_x[slot];
      anchor_y = old_y[slot];
      pix_col  = bg_colour;
`ifdef SPRITE_FLAP_EN
      rom_phase = old_phase[slot];
`endif
    end
    // Zero-extend the anchor, sign-extend the offset; the top bit of the sum
    // flags a negative (off-screen) coordinate.
    sum_x = $signed({1'b0, anchor_x}) + $signed({{(X_W + 1 - DX_W){dx[DX_W-1]}}, dx});
    sum_y = $signed({1'b0, anchor_y}) + $signed({{(Y_W + 1 - DY_W){dy[DY_W-1]}}, dy});
    pix_state = (state == S_ERASE) || (state == S_DRAW);
    on_screen = !sum_x[X_W] && (sum_x[X_W-1:0] <= X_LIM) &&
                !sum_y[Y_W] && (sum_y[Y_W-1:0] <= Y_LIM);
    plot   = pix_state && on_screen;
    x      = plot ? sum_x[X_W-1:0] : '0;
    y      = plot ? sum_y[Y_W-1:0] : '0;
    colour = plot ? pix_col : '0;
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: directed bench for sprite_plotter with two sprite slots.
// A small reference model of the pass (slot walk, erase/draw, clipping) fills
// an expected queue per cycle; hand-computed values pin down key cycles.
module tb_sprite_plotter;

  localparam int NS   = 2;
  localparam int W    = 21;   // {busy, done, plot, x[7:0], y[6:0], colour[2:0]}
  localparam int MAXC = 120;
`ifdef SPRITE_FLAP_EN
  localparam int PIX = 10;
`else
  localparam int PIX = 13;
`endif

  logic            clk;
  logic            resetn;
  logic            frame_tick;
  logic [NS-1:0]   active;
  logic [NS*8-1:0] pos_x;
  logic [NS*7-1:0] pos_y;
  logic [NS*3-1:0] spr_colour;
  logic [2:0]      bg_colour;
  logic [7:0]      x;
  logic [6:0]      y;
  logic [2:0]      colour;
  logic            plot, busy, done, overrun;

  sprite_plotter #(.NUM_SPRITES(NS)) dut (
    .clock      (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .active     (active),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .spr_colour (spr_colour),
    .bg_colour  (bg_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int shp_dx [13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
  int shp_dy [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};
  int m_prev  [NS];
  int m_ox    [NS];
  int m_oy    [NS];
  int m_oph   [NS];
  int m_phase;

  function automatic void shape(input int kk, input int ph, output int dx, output int dy);
`ifdef SPRITE_FLAP_EN
    if (kk < 7) begin
      dx = shp_dx[kk];
      dy = shp_dy[kk];
    end else begin
      dx = -3 - (kk - 7);
      dy = (ph != 0) ? -(kk - 6) : (kk - 6);
    end
`else
    dx = shp_dx[kk];
    dy = shp_dy[kk];
`endif
  endfunction

  function automatic logic [W-1:0] pix_word(input int ax, input int ay, input int kk,
                                            input int ph, input int col);
    int dx, dy, px, py;
    shape(kk, ph, dx, dy);
    px = ax + dx;
    py = ay + dy;
    if (px < 0 || px > 159 || py < 0 || py > 119)
      return {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0};
    return {1'b1, 1'b0, 1'b1, 8'(px), 7'(py), 3'(col)};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_prev[s] = 0; m_ox[s] = 0; m_oy[s] = 0; m_oph[s] = 0;
    end
    m_phase = 0;
  endtask

  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 1'b0, 18'd0});           // LOAD
    for (int s = 0; s < NS; s++) begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, 18'd0});         // SEL
      if (m_prev[s] != 0)
        for (int kk = 0; kk < PIX; kk++)
          exp_q.push_back(pix_word(m_ox[s], m_oy[s], kk, m_oph[s], int'(bg_colour)));
      if (active[s]) begin
        for (int kk = 0; kk < PIX; kk++)
          exp_q.push_back(pix_word(int'(pos_x[s*8 +: 8]), int'(pos_y[s*7 +: 7]), kk,
                                   m_phase, int'(spr_colour[s*3 +: 3])));
        m_prev[s] = 1;
        m_ox[s]   = int'(pos_x[s*8 +: 8]);
        m_oy[s]   = int'(pos_y[s*7 +: 7]);
        m_oph[s]  = m_phase;
      end else begin
        m_prev[s] = 0;
      end
    end
    exp_q.push_back({1'b1, 1'b1, 1'b0, 18'd0});           // DONE
    m_phase = 1 - m_phase;
  endtask

  // ---------------- observation store ----------------
  logic       obs_busy [MAXC+1];
  logic       obs_done [MAXC+1];
  logic       obs_plot [MAXC+1];
  logic [7:0] obs_x    [MAXC+1];
  logic [6:0] obs_y    [MAXC+1];
  logic [2:0] obs_col  [MAXC+1];
  int busy_cnt, done_cnt, ovr_cnt;

  // ---------------- driver tasks ----------------
  task automatic set_slot(input int s, input int px, input int py, input int col);
    pos_x[s*8 +: 8]      = 8'(px);
    pos_y[s*7 +: 7]      = 7'(py);
    spr_colour[s*3 +: 3] = 3'(col);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_overrun", overrun, 0);
    check("rst_xyc", {x, y, colour}, 0);
    resetn = 1'b1;
    model_reset();
  endtask

  // Cycle c is sampled at the negedge following edge c-1 after the tick edge.
  task automatic run_pass(input string name, input int extra_at, output int done_at);
    int n_exp;
    logic [W-1:0] got, e;
    build_expected();
    n_exp = exp_q.size();
    done_at = 0; busy_cnt = 0; done_cnt = 0; ovr_cnt = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      frame_tick = (c == extra_at);
      obs_busy[c] = busy; obs_done[c] = done; obs_plot[c] = plot;
      obs_x[c] = x; obs_y[c] = y; obs_col[c] = colour;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (overrun) ovr_cnt++;
      got = {busy, done, plot, x, y, colour};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e[18]) begin
          e[2:0] = 3'd0;
          got[2:0] = 3'd0;
        end
        check($sformatf("%s_c%0d", name, c), got, e);
      end
      if (done) begin
        done_at = c;
        break;
      end
    end
    if (done_at == 0) check({name, "_timeout"}, 0, 1);
    check({name, "_len"}, done_at, n_exp);
    @(negedge clk);
    if (overrun) ovr_cnt++;
    obs_busy[done_at + 1] = busy;
    check({name, "_idle_after"}, {busy, done, plot}, 0);
  endtask

  // ---------------- directed tests ----------------
  int d_at;
  int idle_busy;

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; active = '0;
    pos_x = '0; pos_y = '0; spr_colour = '0; bg_colour = 3'd2;
    do_reset();

    // 1: single sprite drawn fresh
    active = 2'b01;
    set_slot(0, 20, 30, 7);
    run_pass("t1", 0, d_at);
`ifndef SPRITE_FLAP_EN
    check("t1_done_at", d_at, 17);
    check("t1_first", {obs_plot[3], obs_x[3], obs_y[3], obs_col[3]}, {1'b1, 8'd20, 7'd30, 3'd7});
    check("t1_second", {obs_plot[4], obs_x[4], obs_y[4]}, {1'b1, 8'd20, 7'd31});
    check("t1_last", {obs_plot[15], obs_x[15], obs_y[15]}, {1'b1, 8'd15, 7'd27});
    check("t1_no_plot_c16", obs_plot[16], 0);
    check("t1_busy_cycles", busy_cnt, 17);
    check("t1_done_count", done_cnt, 1);
`endif

    // 2: move sprite -> erase old, draw new
    set_slot(0, 40, 30, 7);
    run_pass("t2", 0, d_at);
`ifndef SPRITE_FLAP_EN
    check("t2_done_at", d_at, 30);
    check("t2_erase0", {obs_x[3], obs_y[3], obs_col[3]}, {8'd20, 7'd30, 3'd2});
    check("t2_draw0", {obs_x[16], obs_y[16], obs_col[16]}, {8'd40, 7'd30, 3'd7});
`endif

    // 3: clipping at the top-left edge
    set_slot(0, 2, 0, 7);
    run_pass("t3", 0, d_at);
`ifndef SPRITE_FLAP_EN
    check("t3_done_at", d_at, 30);
    check("t3_k3_onscreen", {obs_plot[19], obs_x[19], obs_y[19]}, {1'b1, 8'd0, 7'd0});
    check("t3_k4_clipped", {obs_plot[20], obs_x[20], obs_y[20]}, 0);
    check("t3_k8_clipped", {obs_plot[24], obs_x[24], obs_y[24]}, 0);
`endif

    // 4: tick while busy -> one overrun pulse, no extra pass
    set_slot(0, 60, 50, 6);
    run_pass("t4", 5, d_at);
    check("t4_overrun_pulses", ovr_cnt, 1);
    idle_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    check("t4_no_extra_pass", idle_busy, 0);

    // 5: reset in the middle of a pass, then redraw without an erase
    @(negedge clk);
    frame_tick = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (c == 20) begin
        check("t5_busy_before_rst", busy, 1);
        resetn = 1'b0;
      end
    end
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_plot", plot, 0);
    check("t5_rst_done", done, 0);
    resetn = 1'b1;
    model_reset();
    set_slot(0, 80, 60, 6);
    run_pass("t5", 0, d_at);
    check("t5_no_erase_len", d_at, 1 + NS + PIX + 1);

    // 7: two slots, bottom-edge clipping on slot 1, then slot 0 erase-only
    active = 2'b11;
    set_slot(1, 100, 118, 5);
    run_pass("t7a", 0, d_at);
    check("t7a_len", d_at, 1 + NS + 3 * PIX + 1);
    active = 2'b10;
    set_slot(1, 110, 90, 5);
    run_pass("t7b", 0, d_at);
    check("t7b_len", d_at, 1 + NS + 3 * PIX + 1);

`ifdef SPRITE_FLAP_EN
    // 6: wing phase alternates between passes at a fixed position
    do_reset();
    active = 2'b01;
    set_slot(0, 50, 50, 7);
    run_pass("t6a", 0, d_at);
    check("t6a_done_at", d_at, 14);
    check("t6a_wing0", {obs_x[10], obs_y[10]}, {8'd47, 7'd51});
    check("t6a_wing2", {obs_x[12], obs_y[12]}, {8'd45, 7'd53});
    run_pass("t6b", 0, d_at);
    check("t6b_done_at", d_at, 24);
    check("t6b_erase_wing0", {obs_x[10], obs_y[10], obs_col[10]}, {8'd47, 7'd51, 3'd2});
    check("t6b_draw_wing0", {obs_x[20], obs_y[20]}, {8'd47, 7'd49});
    check("t6b_draw_wing2", {obs_x[22], obs_y[22]}, {8'd45, 7'd47});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
